// File: rtl/ram_bist_pkg.sv
// ram_bist_pkg
// Shared definitions for the RAM BIST block: the controller state encoding,
// default geometry and seed, the LFSR feedback taps and the error-count ceiling.
// No ports (package).

package ram_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } bist_state_t;

  localparam int         DEFAULT_DEPTH = 16;
  localparam int         DEFAULT_WIDTH = 8;
  localparam logic [7:0] DEFAULT_SEED  = 8'hA5;

  // Feedback taps on bits 7, 5, 4 and 3 of the 8-bit LFSR.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  localparam logic [4:0] ERR_MAX = 5'd31;

  // An all-zero seed would lock the LFSR at zero, so substitute 8'h01.
  function automatic logic [7:0] effective_seed(input logic [7:0] seed);
    return (seed == 8'h00) ? 8'h01 : seed;
  endfunction

endpackage

// File: rtl/bist_lfsr.sv
// bist_lfsr
// 8-bit Fibonacci LFSR used to generate the BIST data pattern.
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset, forces value to INIT
//   load  - load value from seed (takes priority over step)
//   step  - advance the LFSR by one position
//   seed  - value loaded when load is high
//   value - current LFSR contents

module bist_lfsr
  import ram_bist_pkg::*;
#(
  parameter logic [7:0] INIT = DEFAULT_SEED
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       step,
  input  logic [7:0] seed,
  output logic [7:0] value
);

  // Shift left, feeding the XOR of the tapped bits into bit 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= INIT;
    end else if (load) begin
      value <= seed;
    end else if (step) begin
      value <= {value[6:0], ^(value & LFSR_TAPS)};
    end
  end

endmodule

// File: rtl/ram_bist.sv
// ram_bist
// Single-pass RAM built-in self test: writes an LFSR pattern to every word,
// reads it back, and reports the mismatch count and first failing address.
// Ports:
//   clk       - clock, rising edge
//   rst_n     - asynchronous active-low reset
//   start     - one-cycle test request, honoured only when idle or done
//   rw        - RAM command, 1 = write, 0 = read
//   addr      - RAM address
//   indata    - RAM write data
//   outdata   - RAM read data, valid one clock after the read address
//   busy      - test in progress
//   done      - test finished, held until the next accepted start
//   pass      - no mismatches (meaningful while done is high)
//   err_count - mismatching word count, saturating at 31
//   fail_addr - address of the first mismatch, 0 if none

module ram_bist
  import ram_bist_pkg::*;
#(
  parameter int         DEPTH = DEFAULT_DEPTH,
  parameter int         WIDTH = DEFAULT_WIDTH,
  parameter logic [7:0] SEED  = DEFAULT_SEED
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             rw,
  output logic [3:0]       addr,
  output logic [WIDTH-1:0] indata,
  input  logic [WIDTH-1:0] outdata,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [4:0]       err_count,
  output logic [3:0]       fail_addr
);

  localparam logic [7:0] SEED_EFF  = effective_seed(SEED);
  localparam logic [3:0] LAST_ADDR = 4'(DEPTH - 1);

  bist_state_t      state;
  bist_state_t      next_state;
  logic             lfsr_load;
  logic             lfsr_step;
  logic             addr_clear;
  logic             addr_inc;
  logic             clear_results;
  logic [7:0]       lfsr_value;
  logic             cmp_valid;
  logic [WIDTH-1:0] cmp_data;
  logic [3:0]       cmp_addr;
  logic             mismatch;

  bist_lfsr #(
    .INIT (SEED_EFF)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (lfsr_load),
    .step  (lfsr_step),
    .seed  (SEED_EFF),
    .value (lfsr_value)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // The read pass replays the same LFSR sequence from the seed, so the LFSR
  // value during a read cycle is the word expected back for that address.
  always_comb begin
    next_state    = state;
    lfsr_load     = 1'b0;
    lfsr_step     = 1'b0;
    addr_clear    = 1'b0;
    addr_inc      = 1'b0;
    clear_results = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          next_state    = ST_WRITE;
          lfsr_load     = 1'b1;
          addr_clear    = 1'b1;
          clear_results = 1'b1;
        end
      end
      ST_WRITE: begin
        if (addr == LAST_ADDR) begin
          next_state = ST_READ;
          lfsr_load  = 1'b1;
          addr_clear = 1'b1;
        end else begin
          lfsr_step = 1'b1;
          addr_inc  = 1'b1;
        end
      end
      ST_READ: begin
        lfsr_step = 1'b1;
        if (addr == LAST_ADDR) begin
          next_state = ST_DRAIN;
          addr_clear = 1'b1;
        end else begin
          addr_inc = 1'b1;
        end
      end
      ST_DRAIN: begin
        next_state = ST_DONE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    rw       = (state == ST_WRITE);
    indata   = (state == ST_WRITE) ? WIDTH'(lfsr_value) : '0;
    busy     = (state == ST_WRITE) || (state == ST_READ) || (state == ST_DRAIN);
    done     = (state == ST_DONE);
    pass     = (state == ST_DONE) && (err_count == 5'd0);
    mismatch = cmp_valid && (outdata != cmp_data);
  end

  // Expected data and address are delayed one cycle to line up with the
  // registered RAM read; the last word is compared during DRAIN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr      <= 4'd0;
      cmp_valid <= 1'b0;
      cmp_data  <= '0;
      cmp_addr  <= 4'd0;
      err_count <= 5'd0;
      fail_addr <= 4'd0;
    end else begin
      if (addr_clear) begin
        addr <= 4'd0;
      end else if (addr_inc) begin
        addr <= addr + 4'd1;
      end
      cmp_valid <= (state == ST_READ);
      cmp_data  <= WIDTH'(lfsr_value);
      cmp_addr  <= addr;
      if (clear_results) begin
        err_count <= 5'd0;
        fail_addr <= 4'd0;
      end else if (mismatch) begin
        if (err_count == 5'd0) begin
          fail_addr <= cmp_addr;
        end
        if (err_count != ERR_MAX) begin
          err_count <= err_count + 5'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ram_bist.sv
// tb_ram_bist
// Self-checking bench for ram_bist: a behavioural RAM with selectable faults
// and a reference model that predicts the written pattern and the test result.
// No ports.

module tb_ram_bist;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       rw;
  logic [3:0] addr;
  logic [7:0] indata;
  logic [7:0] outdata;
  logic       busy;
  logic       done;
  logic       pass;
  logic [4:0] err_count;
  logic [3:0] fail_addr;

  logic       start_s0;
  logic       rw_s0;
  logic [3:0] addr_s0;
  logic [7:0] indata_s0;
  logic [7:0] outdata_s0;
  logic       busy_s0;
  logic       done_s0;
  logic       pass_s0;
  logic [4:0] err_count_s0;
  logic [3:0] fail_addr_s0;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [16];
  logic [7:0] rd_q;
  logic [3:0] rd_addr_q;
  int         fault_mode;
  logic [7:0] xor_mask [16];

  ram_bist dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .rw        (rw),
    .addr      (addr),
    .indata    (indata),
    .outdata   (outdata),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_count (err_count),
    .fail_addr (fail_addr)
  );

  ram_bist #(.SEED(8'h00)) dut_s0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start_s0),
    .rw        (rw_s0),
    .addr      (addr_s0),
    .indata    (indata_s0),
    .outdata   (outdata_s0),
    .busy      (busy_s0),
    .done      (done_s0),
    .pass      (pass_s0),
    .err_count (err_count_s0),
    .fail_addr (fail_addr_s0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Faulty-RAM behaviour: 1 = bit 0 of word 5 stuck at 0, 2 = reads return 0,
  // 3 = per-address XOR corruption of the read data.
  function automatic logic [7:0] apply_fault(input logic [7:0] d, input logic [3:0] a,
                                             input int mode, input logic [7:0] m);
    case (mode)
      1:       return (a == 4'd5) ? (d & 8'hFE) : d;
      2:       return 8'h00;
      3:       return d ^ m;
      default: return d;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rw) mem[addr] <= indata;
    rd_q      <= mem[addr];
    rd_addr_q <= addr;
  end

  always_comb begin
    outdata = apply_fault(rd_q, rd_addr_q, fault_mode, xor_mask[rd_addr_q]);
  end

  function automatic logic [7:0] lfsr_next(input logic [7:0] x);
    return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
  endfunction

  // Word the test writes to address a: the seed advanced a times.
  function automatic logic [7:0] expected_word(input logic [7:0] seed, input int a);
    logic [7:0] x;
    x = (seed == 8'h00) ? 8'h01 : seed;
    for (int i = 0; i < a; i++) x = lfsr_next(x);
    return x;
  endfunction

  // Predicted result: walk every address, read it back through the fault model.
  task automatic compute_expected(output logic [4:0] ec, output logic [3:0] fa);
    int cnt;
    logic [7:0] want;
    cnt = 0;
    fa  = 4'd0;
    for (int a = 0; a < 16; a++) begin
      want = expected_word(8'hA5, a);
      if (apply_fault(want, 4'(a), fault_mode, xor_mask[a]) != want) begin
        if (cnt == 0) fa = 4'(a);
        cnt++;
      end
    end
    ec = (cnt > 31) ? 5'd31 : 5'(cnt);
  endtask

  task automatic run_bist(input int restart_at, output int done_edge, output int busy_cycles,
                          output int writes, output logic [7:0] w0, output logic [7:0] w1,
                          output logic done_e1, output logic [4:0] ec_e1);
    done_edge   = -1;
    busy_cycles = 0;
    writes      = 0;
    w0 = 8'h00; w1 = 8'h00; done_e1 = 1'b1; ec_e1 = 5'h1F;
    @(negedge clk);
    start = 1'b1;
    for (int e = 1; e <= 200; e++) begin
      @(posedge clk);
      #1;
      if (e == 1) begin
        start   = 1'b0;
        done_e1 = done;
        ec_e1   = err_count;
      end
      if (restart_at != 0 && e == restart_at)     start = 1'b1;
      if (restart_at != 0 && e == restart_at + 1) start = 1'b0;
      if (busy) busy_cycles++;
      if (rw) writes++;
      if (e == 1 && rw) w0 = indata;
      if (e == 2 && rw) w1 = indata;
      if (done) begin
        done_edge = e;
        break;
      end
    end
  endtask

  // Runs one test and compares timing and result against the model.
  task automatic check_run(input string name, input int restart_at);
    int de, bc, wr;
    logic [7:0] w0, w1;
    logic d1;
    logic [4:0] ec1, ec_exp;
    logic [3:0] fa_exp;
    compute_expected(ec_exp, fa_exp);
    run_bist(restart_at, de, bc, wr, w0, w1, d1, ec1);
    checks++;
    if (de !== 34) begin
      errors++;
      $display("[TB] FAIL %s done_edge: got %0d expected 34", name, de);
    end
    checks++;
    if (bc !== 33 || wr !== 16) begin
      errors++;
      $display("[TB] FAIL %s busy/write cycles: got %0d/%0d expected 33/16", name, bc, wr);
    end
    checks++;
    if (d1 !== 1'b0 || ec1 !== 5'd0) begin
      errors++;
      $display("[TB] FAIL %s cleared_on_start: got done=%0b err=%0d expected 0/0", name, d1, ec1);
    end
    checks++;
    if (w0 !== expected_word(8'hA5, 0) || w1 !== expected_word(8'hA5, 1)) begin
      errors++;
      $display("[TB] FAIL %s first_writes: got %h %h expected %h %h", name, w0, w1,
               expected_word(8'hA5, 0), expected_word(8'hA5, 1));
    end
    checks++;
    if (err_count !== ec_exp || fail_addr !== fa_exp || pass !== (ec_exp == 5'd0)) begin
      errors++;
      $display("[TB] FAIL %s result: got err=%0d fail=%0d pass=%0b expected err=%0d fail=%0d pass=%0b",
               name, err_count, fail_addr, pass, ec_exp, fa_exp, ec_exp == 5'd0);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; start_s0 = 1'b0; outdata_s0 = 8'h00;
    fault_mode = 0;
    for (int a = 0; a < 16; a++) begin
      mem[a] = 8'h00;
      xor_mask[a] = 8'h00;
    end
    #12;
    checks++;
    if ({rw, addr, indata, busy, done, pass, err_count, fail_addr} !== 25'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %h expected 0",
               {rw, addr, indata, busy, done, pass, err_count, fail_addr});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_fault_free();
    int bad;
    fault_mode = 0;
    check_run("fault_free", 0);
    bad = 0;
    for (int a = 0; a < 16; a++) if (mem[a] !== expected_word(8'hA5, a)) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("[TB] FAIL ram_contents: got %0d wrong words expected 0", bad);
    end
    checks++;
    if (pass !== 1'b1 || err_count !== 5'd0 || fail_addr !== 4'd0) begin
      errors++;
      $display("[TB] FAIL fault_free_const: got pass=%0b err=%0d fail=%0d expected 1/0/0",
               pass, err_count, fail_addr);
    end
  endtask

  task automatic test_done_hold();
    repeat (5) @(negedge clk);
    checks++;
    if ({done, busy, rw, addr, indata} !== {1'b1, 1'b0, 1'b0, 4'd0, 8'd0}) begin
      errors++;
      $display("[TB] FAIL done_hold: got done=%0b busy=%0b rw=%0b addr=%0d indata=%h expected 1 0 0 0 00",
               done, busy, rw, addr, indata);
    end
  endtask

  task automatic test_stuck_bit();
    fault_mode = 1;
    check_run("stuck_bit", 0);
    checks++;
    if (pass !== 1'b0 || err_count !== 5'd1 || fail_addr !== 4'd5) begin
      errors++;
      $display("[TB] FAIL stuck_bit_const: got pass=%0b err=%0d fail=%0d expected 0/1/5",
               pass, err_count, fail_addr);
    end
  endtask

  task automatic test_all_zero();
    fault_mode = 2;
    check_run("all_zero", 0);
    checks++;
    if (pass !== 1'b0 || err_count !== 5'd16 || fail_addr !== 4'd0) begin
      errors++;
      $display("[TB] FAIL all_zero_const: got pass=%0b err=%0d fail=%0d expected 0/16/0",
               pass, err_count, fail_addr);
    end
  endtask

  task automatic test_back_to_back();
    fault_mode = 0;
    check_run("restart_ignored", 10);
  endtask

  task automatic test_mid_reset();
    int seen_done;
    fault_mode = 0;
    seen_done = 0;
    @(negedge clk);
    start = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk);
      #1;
      if (e == 1) start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({rw, addr, indata, busy, done, pass, err_count, fail_addr} !== 25'd0) begin
      errors++;
      $display("[TB] FAIL mid_reset_outputs: got %h expected 0",
               {rw, addr, indata, busy, done, pass, err_count, fail_addr});
    end
    repeat (3) begin
      @(posedge clk);
      #1;
      if (done) seen_done++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done || busy) seen_done++;
    end
    checks++;
    if (seen_done != 0) begin
      errors++;
      $display("[TB] FAIL mid_reset_idle: got %0d cycles with done/busy expected 0", seen_done);
    end
    check_run("after_reset", 0);
  endtask

  task automatic test_seed_zero();
    logic [7:0] v0, v1;
    @(negedge clk);
    start_s0 = 1'b1;
    @(posedge clk);
    #1;
    start_s0 = 1'b0;
    v0 = rw_s0 ? indata_s0 : 8'hFF;
    @(posedge clk);
    #1;
    v1 = rw_s0 ? indata_s0 : 8'hFF;
    checks++;
    if (v0 !== expected_word(8'h00, 0) || v1 !== expected_word(8'h00, 1)) begin
      errors++;
      $display("[TB] FAIL seed_zero: got %h %h expected %h %h", v0, v1,
               expected_word(8'h00, 0), expected_word(8'h00, 1));
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      fault_mode = 3;
      for (int a = 0; a < 16; a++)
        xor_mask[a] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      check_run("random_faults", 0);
    end
    for (int a = 0; a < 16; a++) xor_mask[a] = 8'h00;
  endtask

  initial begin
    test_reset();
    test_fault_free();
    test_done_hold();
    test_stuck_bit();
    test_all_zero();
    test_back_to_back();
    test_random();
    test_mid_reset();
    test_seed_zero();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
